fir_coeff_loader: RTL and testbench

Sequences coefficient loading for the FIR datapath. It consumes the coefficient word stream produced by the AXI-monitoring control unit (coeff_data_valid/coeff_data) and writes the words, in tap order, into the shadow bank of a double-buffered tap register file. When a full set has been written, it swaps the active and shadow banks on the next sample boundary, so the filter never computes with a partially loaded set.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_coeff_loader.sv | 154 +++++++++++++++
 tb/tb_fir_coeff_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient-loading logic.
package fir_pkg;

    localparam int FIR_MAX_TAPS = 16;
    localparam int FIR_COEFF_W  = 32;
    localparam int FIR_IDX_W    = $clog2(FIR_MAX_TAPS);

    typedef logic [FIR_IDX_W-1:0] fir_tap_idx_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } fir_ld_state_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// Streams coefficient words into the shadow tap bank, then swaps banks on a
// sample boundary so the datapath only ever sees a complete coefficient set.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int MAX_TAPS = FIR_MAX_TAPS,
    parameter int COEFF_W  = FIR_COEFF_W,
    parameter int IDX_W    = $clog2(MAX_TAPS)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load_start,
    input  logic [IDX_W:0]     num_taps,
    input  logic               coeff_data_valid,
    input  logic [COEFF_W-1:0] coeff_data,
    input  logic               sample_strobe,
    input  logic               err_clr,
    output logic               coeff_we,
    output logic               coeff_wbank,
    output logic [IDX_W-1:0]   coeff_waddr,
    output logic [COEFF_W-1:0] coeff_wdata,
    output logic               bank_sel,
    output logic               busy,
    output logic               done,
    output logic               err_overflow,
    output logic               err_cfg
);

    localparam logic [IDX_W:0] MAX_TAPS_W = (IDX_W+1)'(MAX_TAPS);
    localparam logic [IDX_W:0] ONE_W      = (IDX_W+1)'(1);

    fir_ld_state_t      state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     ntaps_q, ntaps_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   waddr_q, waddr_d;
    logic [COEFF_W-1:0] wdata_q, wdata_d;
    logic               bank_q, bank_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               cfg_q, cfg_d;

    logic cfg_legal;
    logic last_word;

    assign cfg_legal = (num_taps != '0) && (num_taps <= MAX_TAPS_W);
    assign last_word = ({1'b0, idx_q} == (ntaps_q - ONE_W));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ntaps_d = ntaps_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        // Sticky flags: a set condition below overrides the clear.
        ovf_d   = ovf_q & ~err_clr;
        cfg_d   = cfg_q & ~err_clr;

        if (load_start) begin
            // A new start always restarts the sequence; the active bank is untouched.
            idx_d = '0;
            if (cfg_legal) begin
                state_d = LOAD;
                ntaps_d = num_taps;
            end else begin
                state_d = IDLE;
                cfg_d   = 1'b1;
            end
            if (coeff_data_valid && (state_q != LOAD)) begin
                ovf_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (coeff_data_valid) begin
                        ovf_d = 1'b1;
                    end
                end
                LOAD: begin
                    if (coeff_data_valid) begin
                        we_d    = 1'b1;
                        waddr_d = idx_q;
                        wdata_d = coeff_data;
                        if (last_word) begin
                            state_d = WAIT_SWAP;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (coeff_data_valid) begin
                        ovf_d = 1'b1;
                    end
                    if (sample_strobe) begin
                        bank_d  = ~bank_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ntaps_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            bank_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ntaps_q <= ntaps_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            bank_q  <= bank_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            cfg_q   <= cfg_d;
        end
    end

    assign coeff_we     = we_q;
    assign coeff_wbank  = ~bank_q;
    assign coeff_waddr  = waddr_q;
    assign coeff_wdata  = wdata_q;
    assign bank_sel     = bank_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = ovf_q;
    assign err_cfg      = cfg_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: load, swap, abort, errors and reset.
module tb_fir_coeff_loader;

    localparam int MAX_TAPS = 16;
    localparam int COEFF_W  = 32;
    localparam int IDX_W    = 4;

    logic               clk = 1'b0;
    logic               rstn;
    logic               load_start;
    logic [IDX_W:0]     num_taps;
    logic               coeff_data_valid;
    logic [COEFF_W-1:0] coeff_data;
    logic               sample_strobe;
    logic               err_clr;
    logic               coeff_we;
    logic               coeff_wbank;
    logic [IDX_W-1:0]   coeff_waddr;
    logic [COEFF_W-1:0] coeff_wdata;
    logic               bank_sel;
    logic               busy;
    logic               done;
    logic               err_overflow;
    logic               err_cfg;

    int total = 0;
    int bad   = 0;

    fir_coeff_loader #(.MAX_TAPS(MAX_TAPS), .COEFF_W(COEFF_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rstn(rstn), .load_start(load_start), .num_taps(num_taps),
        .coeff_data_valid(coeff_data_valid), .coeff_data(coeff_data),
        .sample_strobe(sample_strobe), .err_clr(err_clr),
        .coeff_we(coeff_we), .coeff_wbank(coeff_wbank), .coeff_waddr(coeff_waddr),
        .coeff_wdata(coeff_wdata), .bank_sel(bank_sel), .busy(busy), .done(done),
        .err_overflow(err_overflow), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_start       = 1'b0;
        coeff_data_valid = 1'b0;
        sample_strobe    = 1'b0;
        err_clr          = 1'b0;
    endtask

    // Packed view {we, wbank, waddr, wdata} for write-port comparisons.
    function automatic logic [37:0] wport();
        return {coeff_we, coeff_wbank, coeff_waddr, coeff_wdata};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        num_taps   = '0;
        coeff_data = '0;
        repeat (2) step();
        total++;
        if ({coeff_we, coeff_waddr, coeff_wdata, bank_sel, busy, done, err_overflow, err_cfg} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h bank=%b busy=%b done=%b ovf=%b cfg=%b want all 0",
                     coeff_we, coeff_waddr, coeff_wdata, bank_sel, busy, done, err_overflow, err_cfg);
        end
        total++;
        if (coeff_wbank !== 1'b1) begin
            bad++;
            $display("FAIL reset_wbank: got %b want 1", coeff_wbank);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic(input logic exp_bank_before);
        load_start = 1'b1;
        num_taps   = 5'd4;
        step();
        load_start = 1'b0;
        total++;
        if ({busy, coeff_we} !== 2'b10) begin
            bad++;
            $display("FAIL basic_start: got busy=%b we=%b want busy=1 we=0", busy, coeff_we);
        end
        coeff_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            coeff_data = 32'h11 * (i + 1);
            step();
            total++;
            if (wport() !== {1'b1, ~exp_bank_before, 4'(i), 32'h11 * (i + 1)}) begin
                bad++;
                $display("FAIL basic_write%0d: got %h want %h", i, wport(),
                         {1'b1, ~exp_bank_before, 4'(i), 32'h11 * (i + 1)});
            end
        end
        coeff_data_valid = 1'b0;
        step();
        total++;
        if ({coeff_we, busy, bank_sel, done} !== {1'b0, 1'b1, exp_bank_before, 1'b0}) begin
            bad++;
            $display("FAIL basic_wait: got we=%b busy=%b bank=%b done=%b want we=0 busy=1 bank=%b done=0",
                     coeff_we, busy, bank_sel, done, exp_bank_before);
        end
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        total++;
        if ({bank_sel, done, busy} !== {~exp_bank_before, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL basic_swap: got bank=%b done=%b busy=%b want bank=%b done=1 busy=0",
                     bank_sel, done, busy, ~exp_bank_before);
        end
        step();
        total++;
        if ({done, busy, bank_sel} !== {1'b0, 1'b0, ~exp_bank_before}) begin
            bad++;
            $display("FAIL basic_after: got done=%b busy=%b bank=%b", done, busy, bank_sel);
        end
    endtask

    task automatic test_illegal_cfg();
        logic [IDX_W:0] bad_n [2];
        bad_n[0] = 5'd0;
        bad_n[1] = 5'd17;
        for (int k = 0; k < 2; k++) begin
            load_start = 1'b1;
            num_taps   = bad_n[k];
            step();
            load_start = 1'b0;
            total++;
            if ({err_cfg, busy, coeff_we} !== 3'b100) begin
                bad++;
                $display("FAIL cfg_set_n%0d: got cfg=%b busy=%b we=%b want 1 0 0",
                         bad_n[k], err_cfg, busy, coeff_we);
            end
            step();
            total++;
            if ({err_cfg, busy} !== 2'b10) begin
                bad++;
                $display("FAIL cfg_sticky_n%0d: got cfg=%b busy=%b want 1 0", bad_n[k], err_cfg, busy);
            end
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            total++;
            if (err_cfg !== 1'b0) begin
                bad++;
                $display("FAIL cfg_clear_n%0d: got %b want 0", bad_n[k], err_cfg);
            end
        end
    endtask

    task automatic test_stray(input logic bank0);
        coeff_data_valid = 1'b1;
        coeff_data       = 32'hBAD0;
        step();
        coeff_data_valid = 1'b0;
        total++;
        if ({coeff_we, err_overflow, bank_sel} !== {1'b0, 1'b1, bank0}) begin
            bad++;
            $display("FAIL stray_idle: got we=%b ovf=%b bank=%b want 0 1 %b", coeff_we, err_overflow, bank_sel, bank0);
        end
        // A new stray word together with err_clr: the set must win.
        coeff_data_valid = 1'b1;
        err_clr          = 1'b1;
        step();
        idle_inputs();
        total++;
        if (err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL stray_set_wins: got %b want 1", err_overflow);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL stray_clear: got %b want 0", err_overflow);
        end
        load_start = 1'b1;
        num_taps   = 5'd1;
        step();
        load_start       = 1'b0;
        coeff_data_valid = 1'b1;
        coeff_data       = 32'h5A5A;
        step();
        total++;
        if ({coeff_we, err_overflow} !== 2'b10) begin
            bad++;
            $display("FAIL stray_load_word: got we=%b ovf=%b want 1 0", coeff_we, err_overflow);
        end
        coeff_data = 32'hBAD1;
        step();
        coeff_data_valid = 1'b0;
        total++;
        if ({coeff_we, err_overflow, bank_sel, busy} !== {1'b0, 1'b1, bank0, 1'b1}) begin
            bad++;
            $display("FAIL stray_wait: got we=%b ovf=%b bank=%b busy=%b want 0 1 %b 1",
                     coeff_we, err_overflow, bank_sel, busy, bank0);
        end
        sample_strobe = 1'b1;
        err_clr       = 1'b1;
        step();
        idle_inputs();
        total++;
        if ({bank_sel, done, err_overflow} !== {~bank0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL stray_swap: got bank=%b done=%b ovf=%b want %b 1 0", bank_sel, done, err_overflow, ~bank0);
        end
    endtask

    task automatic test_abort(input logic bank0);
        load_start = 1'b1;
        num_taps   = 5'd8;
        step();
        load_start       = 1'b0;
        coeff_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            coeff_data = 32'hA0 + i;
            step();
        end
        coeff_data_valid = 1'b0;
        total++;
        if ({coeff_we, coeff_waddr} !== {1'b1, 4'd2}) begin
            bad++;
            $display("FAIL abort_pre: got we=%b addr=%0d want 1 2", coeff_we, coeff_waddr);
        end
        load_start = 1'b1;
        num_taps   = 5'd2;
        step();
        load_start = 1'b0;
        total++;
        if ({busy, coeff_we, bank_sel, err_overflow} !== {1'b1, 1'b0, bank0, 1'b0}) begin
            bad++;
            $display("FAIL abort_restart: got busy=%b we=%b bank=%b ovf=%b", busy, coeff_we, bank_sel, err_overflow);
        end
        coeff_data_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            coeff_data = 32'hB0 + i;
            step();
            total++;
            if (wport() !== {1'b1, ~bank0, 4'(i), 32'hB0 + i}) begin
                bad++;
                $display("FAIL abort_write%0d: got %h want %h", i, wport(), {1'b1, ~bank0, 4'(i), 32'hB0 + i});
            end
        end
        coeff_data_valid = 1'b0;
        step();
        total++;
        if ({busy, bank_sel} !== {1'b1, bank0}) begin
            bad++;
            $display("FAIL abort_wait: got busy=%b bank=%b want 1 %b", busy, bank_sel, bank0);
        end
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        total++;
        if ({bank_sel, done, busy} !== {~bank0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL abort_swap: got bank=%b done=%b busy=%b want %b 1 0", bank_sel, done, busy, ~bank0);
        end
    endtask

    task automatic test_simultaneous(input logic bank0);
        load_start = 1'b1;
        num_taps   = 5'd1;
        step();
        load_start       = 1'b0;
        coeff_data_valid = 1'b1;
        coeff_data       = 32'hC0FFEE;
        sample_strobe    = 1'b1;
        step();
        idle_inputs();
        total++;
        if ({coeff_we, coeff_waddr, bank_sel, done, busy} !== {1'b1, 4'd0, bank0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL simul_last_strobe: got we=%b addr=%0d bank=%b done=%b busy=%b",
                     coeff_we, coeff_waddr, bank_sel, done, busy);
        end
        step();
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        total++;
        if ({bank_sel, done} !== {~bank0, 1'b1}) begin
            bad++;
            $display("FAIL simul_second_strobe: got bank=%b done=%b want %b 1", bank_sel, done, ~bank0);
        end
        // Full-depth load; the word coincident with load_start is dropped.
        load_start       = 1'b1;
        num_taps         = 5'd16;
        coeff_data_valid = 1'b1;
        coeff_data       = 32'hDEAD;
        step();
        load_start = 1'b0;
        total++;
        if ({coeff_we, err_overflow, busy} !== 3'b011) begin
            bad++;
            $display("FAIL simul_start_word: got we=%b ovf=%b busy=%b want 0 1 1", coeff_we, err_overflow, busy);
        end
        for (int i = 0; i < 16; i++) begin
            coeff_data = 32'h01010101 * i;
            step();
            total++;
            if (wport() !== {1'b1, bank0, 4'(i), 32'h01010101 * i}) begin
                bad++;
                $display("FAIL full_write%0d: got %h want %h", i, wport(), {1'b1, bank0, 4'(i), 32'h01010101 * i});
            end
        end
        coeff_data_valid = 1'b0;
        err_clr          = 1'b1;
        step();
        err_clr       = 1'b0;
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        total++;
        if ({bank_sel, done, busy, err_overflow} !== {bank0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL full_swap: got bank=%b done=%b busy=%b ovf=%b want %b 1 0 0",
                     bank_sel, done, busy, err_overflow, bank0);
        end
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        num_taps   = 5'd4;
        step();
        load_start       = 1'b0;
        coeff_data_valid = 1'b1;
        coeff_data       = 32'h77;
        repeat (2) step();
        coeff_data_valid = 1'b0;
        rstn = 1'b0;
        #2;
        total++;
        if ({coeff_we, coeff_waddr, coeff_wdata, bank_sel, busy, done, err_overflow, err_cfg, coeff_wbank} !== 46'd1) begin
            bad++;
            $display("FAIL reset_mid_load: got we=%b addr=%0d data=%h bank=%b busy=%b wbank=%b want zeros, wbank=1",
                     coeff_we, coeff_waddr, coeff_wdata, bank_sel, busy, coeff_wbank);
        end
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_illegal_cfg();
        test_stray(1'b1);
        test_abort(1'b0);
        test_simultaneous(1'b1);
        test_reset_mid_load();
        test_basic(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
